// File: rtl/gpio_led_arbiter.sv
// gpio_led_arbiter: round-robin arbiter between a CPU and an auxiliary LED
// writer. It latches the granted pattern and hands it to a parallel-to-serial
// LED shifter with a start/done handshake and a WAIT timeout.
// Optional feature macro: LED_ARB_SKIP_DUP_EN (grant a pattern that equals the
// last completed transfer without restarting the shifter).
module gpio_led_arbiter #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_cpu,
    input  logic [DATA_BITS-1:0] data_cpu,
    input  logic                 req_aux,
    input  logic [DATA_BITS-1:0] data_aux,
    output logic                 gnt_cpu,
    output logic                 gnt_aux,
    output logic                 p2s_start,
    output logic [DATA_BITS-1:0] p2s_data,
    input  logic                 p2s_done,
    output logic                 busy,
    output logic                 timeout_err
);

    // The counter only needs to reach TIMEOUT-1: the abort fires on the edge
    // where it would step to TIMEOUT.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   gnt_cpu_q, gnt_cpu_d;
    logic                   gnt_aux_q, gnt_aux_d;
    logic                   start_q, start_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   terr_q, terr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_aux_q, last_aux_d;

    logic                   any_req_c;
    logic                   pick_cpu_c;
    logic [DATA_BITS-1:0]   pick_data_c;
    logic                   timeout_hit_c;
    logic                   skip_c;

    // Requester selection: a tie goes to whoever was not granted last.
    always_comb begin
        any_req_c     = req_cpu | req_aux;
        pick_cpu_c    = req_cpu & (~req_aux | last_aux_q);
        pick_data_c   = pick_cpu_c ? data_cpu : data_aux;
        timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

`ifdef LED_ARB_SKIP_DUP_EN
    logic [DATA_BITS-1:0]   last_done_q, last_done_d;
    logic                   have_done_q, have_done_d;

    // A grant repeating the last completed pattern does not restart the shifter.
    always_comb begin
        skip_c      = have_done_q & (pick_data_c == last_done_q);
        last_done_d = last_done_q;
        have_done_d = have_done_q;
        if ((state_q == S_WAIT) && p2s_done) begin
            last_done_d = data_q;
            have_done_d = 1'b1;
        end
    end

    // Record of the last successfully shifted pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_done_q <= '0;
            have_done_q <= 1'b0;
        end else begin
            last_done_q <= last_done_d;
            have_done_q <= have_done_d;
        end
    end
`else
    // Every grant starts a transfer.
    always_comb begin
        skip_c = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req_c && !skip_c) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (p2s_done || timeout_hit_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; done beats a coincident timeout.
    always_comb begin
        gnt_cpu_d  = 1'b0;
        gnt_aux_d  = 1'b0;
        start_d    = 1'b0;
        data_d     = data_q;
        terr_d     = terr_q;
        cnt_d      = cnt_q;
        last_aux_d = last_aux_q;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req_c) begin
                    gnt_cpu_d  = pick_cpu_c;
                    gnt_aux_d  = ~pick_cpu_c;
                    data_d     = pick_data_c;
                    terr_d     = 1'b0;
                    last_aux_d = ~pick_cpu_c;
                end
            end
            S_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!p2s_done && timeout_hit_c) terr_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath; last-granted resets to aux so CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cpu_q  <= 1'b0;
            gnt_aux_q  <= 1'b0;
            start_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            cnt_q      <= '0;
            last_aux_q <= 1'b1;
        end else begin
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_aux_q  <= gnt_aux_d;
            start_q    <= start_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            cnt_q      <= cnt_d;
            last_aux_q <= last_aux_d;
        end
    end

    assign gnt_cpu     = gnt_cpu_q;
    assign gnt_aux     = gnt_aux_q;
    assign p2s_start   = start_q;
    assign p2s_data    = data_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_gpio_led_arbiter.sv
// Directed bench for gpio_led_arbiter (TIMEOUT overridden to 8).
// Cycle k denotes the interval after the k-th rising edge following a grant.
module tb_gpio_led_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_cpu, req_aux;
    logic [15:0] data_cpu, data_aux;
    logic        gnt_cpu, gnt_aux, p2s_start, busy, timeout_err, p2s_done;
    logic [15:0] p2s_data;

    int total = 0;
    int bad   = 0;
    int aux_seen   = 0;
    int start_seen = 0;
    int base_aux, base_start;

    gpio_led_arbiter #(.DATA_BITS(16), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_cpu    (req_cpu),
        .data_cpu   (data_cpu),
        .req_aux    (req_aux),
        .data_aux   (data_aux),
        .gnt_cpu    (gnt_cpu),
        .gnt_aux    (gnt_aux),
        .p2s_start  (p2s_start),
        .p2s_data   (p2s_data),
        .p2s_done   (p2s_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Running tallies of pulses for "never happened" checks.
    always @(negedge clk) begin
        if (gnt_aux)   aux_seen   <= aux_seen + 1;
        if (p2s_start) start_seen <= start_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_cpu = 1'b0; req_aux = 1'b0;
        data_cpu = '0; data_aux = '0; p2s_done = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_gnt_cpu", 32'(gnt_cpu), 0);
        chk("rst_gnt_aux", 32'(gnt_aux), 0);
        chk("rst_start",   32'(p2s_start), 0);
        chk("rst_data",    32'(p2s_data), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_terr",    32'(timeout_err), 0);

        // Single CPU write with done in cycle 5.
        req_cpu = 1'b1; data_cpu = 16'h00A5;
        step();
        chk("t1_gnt_cpu_c0", 32'(gnt_cpu), 1);
        chk("t1_gnt_aux_c0", 32'(gnt_aux), 0);
        chk("t1_start_c0",   32'(p2s_start), 0);
        chk("t1_busy_c0",    32'(busy), 1);
        chk("t1_data_c0",    32'(p2s_data), 32'h00A5);
        req_cpu = 1'b0;
        step();
        chk("t1_start_c1",   32'(p2s_start), 1);
        chk("t1_gnt_cpu_c1", 32'(gnt_cpu), 0);
        step();
        chk("t1_start_c2",   32'(p2s_start), 0);
        step(); step(); step();
        p2s_done = 1'b1;
        chk("t1_busy_c5",    32'(busy), 1);
        step();
        p2s_done = 1'b0;
        chk("t1_busy_c6",    32'(busy), 0);
        chk("t1_data_hold",  32'(p2s_data), 32'h00A5);

        // Done while idle is ignored.
        base_start = start_seen;
        p2s_done = 1'b1;
        step();
        p2s_done = 1'b0;
        step();
        chk("idle_done_busy",  32'(busy), 0);
        chk("idle_done_start", 32'(start_seen - base_start), 0);

        // Tie right after reset: CPU first, then aux.
        rst = 1'b1; step(); rst = 1'b0; step();
        req_cpu = 1'b1; req_aux = 1'b1; data_cpu = 16'h1111; data_aux = 16'h2222;
        step();
        chk("rr_gnt_cpu", 32'(gnt_cpu), 1);
        chk("rr_gnt_aux", 32'(gnt_aux), 0);
        chk("rr_data1",   32'(p2s_data), 32'h1111);
        req_cpu = 1'b0;
        step(); step();
        chk("rr_aux_ignored", 32'(gnt_aux), 0);
        p2s_done = 1'b1;
        step();
        p2s_done = 1'b0;
        chk("rr_idle", 32'(busy), 0);
        step();
        chk("rr_gnt_aux2", 32'(gnt_aux), 1);
        chk("rr_data2",    32'(p2s_data), 32'h2222);
        req_aux = 1'b0;
        step(); step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;
        // Aux was last: next tie goes to CPU.
        req_cpu = 1'b1; req_aux = 1'b1;
        step();
        chk("rr_gnt_cpu3", 32'(gnt_cpu), 1);
        req_cpu = 1'b0; req_aux = 1'b0;
        step(); step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;

        // Aux request raised and dropped during WAIT is never granted.
        base_aux = aux_seen;
        req_cpu = 1'b1; data_cpu = 16'h3C3C;
        step();
        req_cpu = 1'b0;
        step();
        req_aux = 1'b1; step(); step();
        req_aux = 1'b0; step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;
        step(); step();
        chk("wait_aux_dropped", 32'(aux_seen - base_aux), 0);

        // Timeout: IDLE eight cycles after entering WAIT.
        req_cpu = 1'b1; data_cpu = 16'h0F0F;
        step();
        req_cpu = 1'b0;
        step();
        repeat (7) step();
        chk("to_busy_c8", 32'(busy), 1);
        chk("to_terr_c8", 32'(timeout_err), 0);
        step();
        chk("to_busy_c9", 32'(busy), 0);
        chk("to_terr_c9", 32'(timeout_err), 1);
        step();
        chk("to_terr_sticky", 32'(timeout_err), 1);

        // Next grant clears the flag; done coinciding with timeout wins.
        req_cpu = 1'b1; data_cpu = 16'h0001;
        step();
        chk("to_clr_gnt",  32'(gnt_cpu), 1);
        chk("to_clr_terr", 32'(timeout_err), 0);
        req_cpu = 1'b0;
        step();
        repeat (7) step();
        p2s_done = 1'b1;
        step();
        p2s_done = 1'b0;
        chk("coinc_busy", 32'(busy), 0);
        chk("coinc_terr", 32'(timeout_err), 0);

        // Reset during WAIT aborts the transfer.
        req_cpu = 1'b1; data_cpu = 16'hBEEF;
        step();
        chk("rw_data_full", 32'(p2s_data), 32'hBEEF);
        req_cpu = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rw_busy",  32'(busy), 0);
        chk("rw_data",  32'(p2s_data), 0);
        chk("rw_start", 32'(p2s_start), 0);
        chk("rw_gnt",   32'({gnt_cpu, gnt_aux}), 0);
        chk("rw_terr",  32'(timeout_err), 0);
        base_start = start_seen;
        step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;
        step(); step();
        chk("rw_late_done_busy",  32'(busy), 0);
        chk("rw_late_done_start", 32'(start_seen - base_start), 0);

        // Two identical writes after reset.
        req_cpu = 1'b1; data_cpu = 16'h00FF;
        step();
        req_cpu = 1'b0;
        step();
        chk("dup_first_start", 32'(p2s_start), 1);
        step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;
        base_start = start_seen;
        req_cpu = 1'b1;
        step();
        chk("dup_second_gnt", 32'(gnt_cpu), 1);
        req_cpu = 1'b0;
`ifdef LED_ARB_SKIP_DUP_EN
        chk("dup_second_busy", 32'(busy), 0);
        step(); step();
        chk("dup_second_nostart", 32'(start_seen - base_start), 0);
`else
        chk("dup_second_busy", 32'(busy), 1);
        step();
        chk("dup_second_start", 32'(p2s_start), 1);
        step();
        p2s_done = 1'b1; step(); p2s_done = 1'b0;
        chk("dup_second_done", 32'(busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
